// File: rtl/lick_pkg.sv
// lick_pkg: state encodings and default sizing shared by the lick conditioner files.
package lick_pkg;

  // Default configuration
  localparam int DEBOUNCE_CYC_DEF = 100;
  localparam int HOLD_CYC_DEF     = 4;
  localparam int CNT_W_DEF        = 16;

  // Debounce FSM encodings
  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  // Sync-window FSM encodings
  localparam logic [0:0] W_OPEN = 1'b0;
  localparam logic [0:0] W_HOLD = 1'b1;

  // Rising-edge detect between a current and a one-cycle-delayed sample
  function automatic logic rise_det(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: 1-bit two-flop synchronizer for asynchronous inputs, synchronous reset to 0.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resynchronisation; the first flop absorbs metastability
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lick_conditioner.sv
// lick_conditioner: synchronizes and debounces the raw lick sensor, latches any lick seen
// within a miniscope sync window for the logger, and optionally counts lick onsets.
// Optional feature macro: LICK_COUNT_EN (onset counter; when undefined lick_count is tied to 0).
module lick_conditioner
  import lick_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             sync,
  input  logic             lick_raw,
  output logic             lick_out,
  output logic             lick_clean,
  output logic             lick_onset,
  output logic [CNT_W-1:0] lick_count
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYC);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  logic              lick_s;
  logic              sync_s;
  logic              sync_d;
  logic              sync_edge;

  logic [1:0]        db_state;
  logic [1:0]        db_state_nxt;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nxt;
  logic              clean_nxt;
  logic              onset_nxt;

  logic [0:0]        w_state;
  logic [0:0]        w_state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              win;
  logic              win_nxt;
  logic              pend;
  logic              pend_nxt;
  logic              win_set;
  logic              out_nxt;

  sync2 u_sync_lick (
    .clk   (clk),
    .reset (reset),
    .d     (lick_raw),
    .q     (lick_s)
  );

  sync2 u_sync_frame (
    .clk   (clk),
    .reset (reset),
    .d     (sync),
    .q     (sync_s)
  );

  // Same 0->1 detection on the synchronized frame sync that the logger applies
  assign sync_edge = rise_det(sync_s, sync_d);

  // Anything that marks the current window as containing a lick
  assign win_set = lick_onset | lick_clean;

  // Debounce FSM: a level change must persist DEBOUNCE_CYC cycles past entry before it is accepted
  always_comb begin
    db_state_nxt = db_state;
    db_cnt_nxt   = db_cnt;
    clean_nxt    = lick_clean;
    onset_nxt    = 1'b0;
    case (db_state)
      S_LOW: begin
        if (lick_s) begin
          db_state_nxt = S_RISE;
          db_cnt_nxt   = DB_W'(0);
        end else begin
          db_state_nxt = S_LOW;
        end
      end
      S_RISE: begin
        if (!lick_s) begin
          db_state_nxt = S_LOW;
        end else if (db_cnt == DB_LAST) begin
          db_state_nxt = S_HIGH;
          clean_nxt    = 1'b1;
          onset_nxt    = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      S_HIGH: begin
        if (!lick_s) begin
          db_state_nxt = S_FALL;
          db_cnt_nxt   = DB_W'(0);
        end else begin
          db_state_nxt = S_HIGH;
        end
      end
      S_FALL: begin
        if (lick_s) begin
          db_state_nxt = S_HIGH;
        end else if (db_cnt == DB_LAST) begin
          db_state_nxt = S_LOW;
          clean_nxt    = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        db_state_nxt = S_LOW;
        db_cnt_nxt   = DB_W'(0);
        clean_nxt    = 1'b0;
      end
    endcase
  end

  // Window FSM: freeze lick_out for the logger after a sync edge, park onsets arriving meanwhile
  always_comb begin
    w_state_nxt = w_state;
    hold_nxt    = hold_cnt;
    win_nxt     = win;
    pend_nxt    = pend;
    out_nxt     = lick_out;
    if (!trig) begin
      w_state_nxt = W_OPEN;
      hold_nxt    = HOLD_W'(0);
      win_nxt     = 1'b0;
      pend_nxt    = 1'b0;
      out_nxt     = clean_nxt;
    end else begin
      case (w_state)
        W_OPEN: begin
          win_nxt = win | win_set;
          if (sync_edge) begin
            w_state_nxt = W_HOLD;
            hold_nxt    = HOLD_LAST;
            out_nxt     = lick_out;
          end else begin
            out_nxt = win_nxt | clean_nxt;
          end
        end
        W_HOLD: begin
          if (hold_cnt == HOLD_W'(0)) begin
            w_state_nxt = W_OPEN;
            win_nxt     = pend | win_set;
            pend_nxt    = 1'b0;
            out_nxt     = win_nxt | clean_nxt;
          end else begin
            hold_nxt = hold_cnt - HOLD_W'(1);
            pend_nxt = pend | win_set;
            out_nxt  = lick_out;
          end
        end
        default: begin
          w_state_nxt = W_OPEN;
          hold_nxt    = HOLD_W'(0);
          win_nxt     = 1'b0;
          pend_nxt    = 1'b0;
          out_nxt     = clean_nxt;
        end
      endcase
    end
  end

  // State and output registers; reset returns every flop to its idle value
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_d     <= 1'b0;
      db_state   <= S_LOW;
      db_cnt     <= DB_W'(0);
      lick_clean <= 1'b0;
      lick_onset <= 1'b0;
      w_state    <= W_OPEN;
      hold_cnt   <= HOLD_W'(0);
      win        <= 1'b0;
      pend       <= 1'b0;
      lick_out   <= 1'b0;
    end else begin
      sync_d     <= sync_s;
      db_state   <= db_state_nxt;
      db_cnt     <= db_cnt_nxt;
      lick_clean <= clean_nxt;
      lick_onset <= onset_nxt;
      w_state    <= w_state_nxt;
      hold_cnt   <= hold_nxt;
      win        <= win_nxt;
      pend       <= pend_nxt;
      lick_out   <= out_nxt;
    end
  end

`ifdef LICK_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             trig_d;
  logic [CNT_W-1:0] cnt;

  // Onset counter: cleared on trig rising, saturating increment while recording
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_d <= 1'b0;
      cnt    <= {CNT_W{1'b0}};
    end else begin
      trig_d <= trig;
      if (rise_det(trig, trig_d)) begin
        cnt <= lick_onset ? CNT_W'(1) : {CNT_W{1'b0}};
      end else if (trig && lick_onset && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= cnt;
      end
    end
  end

  assign lick_count = cnt;
`else
  assign lick_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lick_conditioner.sv
// tb_lick_conditioner: directed table/sequence checks plus randomized run against a
// behavioural model. Works with or without LICK_COUNT_EN defined.
module tb_lick_conditioner;

  localparam int DB   = 8;
  localparam int HOLD = 4;
  localparam int CW   = 16;
  localparam int CWS  = 3;

  logic clk = 1'b0;
  logic reset, trig, sync, lick_raw;
  logic lick_out, lick_clean, lick_onset;
  logic [CW-1:0]  lick_count;
  logic s_out, s_clean, s_onset;
  logic [CWS-1:0] s_count;

  always #5 clk = ~clk;

  lick_conditioner #(.DEBOUNCE_CYC(DB), .HOLD_CYC(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .trig(trig), .sync(sync), .lick_raw(lick_raw),
    .lick_out(lick_out), .lick_clean(lick_clean), .lick_onset(lick_onset),
    .lick_count(lick_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run
  lick_conditioner #(.DEBOUNCE_CYC(DB), .HOLD_CYC(HOLD), .CNT_W(CWS)) dut_small (
    .clk(clk), .reset(reset), .trig(trig), .sync(sync), .lick_raw(lick_raw),
    .lick_out(s_out), .lick_clean(s_clean), .lick_onset(s_onset),
    .lick_count(s_count)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int onset_seen = 0;

  // Behavioural model state
  bit [1:0]    m_rawh;
  bit [2:0]    m_synch;
  bit          m_trig_p;
  bit          m_clean, m_onset, m_out, m_win, m_pend, m_hold;
  int          m_run, m_left;
  int unsigned m_cnt, m_cnt_s;

  typedef struct {
    bit raw;
    int ncyc;
    bit exp_clean;
    int exp_onsets;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_count(input int unsigned v);
`ifdef LICK_COUNT_EN
    return 64'(v);
`else
    return 64'd0;
`endif
  endfunction

  // Model of one clock edge: clean flips after DB+1 consecutive disagreeing samples
  task automatic mdl_edge();
    bit s, se, tr, old_clean, old_onset, wset;
    if (reset) begin
      m_rawh = 2'b00; m_synch = 3'b000; m_trig_p = 1'b0;
      m_clean = 1'b0; m_onset = 1'b0; m_out = 1'b0; m_win = 1'b0; m_pend = 1'b0;
      m_hold = 1'b0; m_run = 0; m_left = 0; m_cnt = 0; m_cnt_s = 0;
      return;
    end
    s  = m_rawh[1];
    se = m_synch[1] & ~m_synch[2];
    m_rawh  = {m_rawh[0], lick_raw};
    m_synch = {m_synch[1:0], sync};
    tr = trig & ~m_trig_p;
    m_trig_p = trig;
    old_clean = m_clean;
    old_onset = m_onset;
    wset = old_clean | old_onset;

    if (s != m_clean) m_run++;
    else m_run = 0;
    m_onset = 1'b0;
    if (m_run == DB + 1) begin
      m_clean = s;
      m_onset = s;
      m_run   = 0;
    end

    if (tr) begin
      m_cnt   = old_onset ? 1 : 0;
      m_cnt_s = old_onset ? 1 : 0;
    end else if (trig && old_onset) begin
      if (m_cnt < (2**CW) - 1) m_cnt++;
      if (m_cnt_s < (2**CWS) - 1) m_cnt_s++;
    end

    if (!trig) begin
      m_hold = 1'b0; m_win = 1'b0; m_pend = 1'b0; m_out = m_clean;
    end else if (!m_hold) begin
      m_win = m_win | wset;
      if (se) begin
        m_hold = 1'b1;
        m_left = HOLD - 1;
      end else begin
        m_out = m_win | m_clean;
      end
    end else begin
      m_pend = m_pend | wset;
      if (m_left == 0) begin
        m_hold = 1'b0;
        m_win  = m_pend;
        m_pend = 1'b0;
        m_out  = m_win | m_clean;
      end else begin
        m_left--;
      end
    end
  endtask

  // One clock: model advances on the edge, DUTs compared on the falling edge
  task automatic step();
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
    if (lick_onset === 1'b1) onset_seen++;
    chk("mdl_clean", lick_clean, m_clean);
    chk("mdl_onset", lick_onset, m_onset);
    chk("mdl_out",   lick_out,   m_out);
    chk("mdl_count", lick_count, exp_count(m_cnt));
    chk("mdl_count_small", s_count, exp_count(m_cnt_s));
    chk("mdl_out_small", s_out, m_out);
  endtask

  initial begin
    int lat;
    int raw_left, sync_left;

    reset = 1'b1; trig = 1'b0; sync = 1'b0; lick_raw = 1'b0;
    tbl[0]  = '{1'b1, 1,  1'b0, 0};
    tbl[1]  = '{1'b0, 20, 1'b0, 0};
    tbl[2]  = '{1'b1, 3,  1'b0, 0};
    tbl[3]  = '{1'b0, 20, 1'b0, 0};
    tbl[4]  = '{1'b1, 7,  1'b0, 0};
    tbl[5]  = '{1'b0, 20, 1'b0, 0};
    tbl[6]  = '{1'b1, 8,  1'b0, 0};
    tbl[7]  = '{1'b0, 20, 1'b0, 0};
    tbl[8]  = '{1'b1, 9,  1'b0, 0};
    tbl[9]  = '{1'b0, 4,  1'b1, 1};
    tbl[10] = '{1'b0, 20, 1'b0, 0};

    // Reset state
    step(); step();
    chk("rst_out", lick_out, 1'b0);
    chk("rst_clean", lick_clean, 1'b0);
    chk("rst_onset", lick_onset, 1'b0);
    chk("rst_count", lick_count, 64'd0);
    reset = 1'b0;
    trig  = 1'b1;
    repeat (3) step();

    // 1: held lick, latency DB+2 edges from first sampling edge
    lick_raw = 1'b1; onset_seen = 0; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (lick_clean === 1'b1 && lat < 0) lat = i;
    end
    chk("t1_latency", lat - 1, DB + 2);
    chk("t1_onsets", onset_seen, 1);
    chk("t1_count", lick_count, exp_count(1));
    lick_raw = 1'b0;
    repeat (20) step();

    // 2: bursts shorter than the debounce window, then a just-long-enough pulse
    for (int i = 0; i < 11; i++) begin
      lick_raw = tbl[i].raw;
      onset_seen = 0;
      repeat (tbl[i].ncyc) step();
      chk($sformatf("t2_clean_row%0d", i), lick_clean, tbl[i].exp_clean);
      chk($sformatf("t2_onsets_row%0d", i), onset_seen, tbl[i].exp_onsets);
      if (i == 7) chk("t2_count", lick_count, exp_count(1));
    end

    // 3: short lick between two sync edges ~1000 cycles apart
    sync = 1'b1; repeat (8) step();
    sync = 1'b0; repeat (10) step();
    chk("t3_idle", lick_out, 1'b0);
    repeat (400) step();
    lick_raw = 1'b1; repeat (20) step();
    lick_raw = 1'b0; repeat (560) step();
    chk("t3_pre", lick_out, 1'b1);
    sync = 1'b1; step(); step();
    for (int k = 0; k < HOLD; k++) begin
      step();
      chk("t3_hold", lick_out, 1'b1);
    end
    step();
    chk("t3_after", lick_out, 1'b0);
    sync = 1'b0;

    // 4: onset landing inside a hold stays out of the frozen sample
    repeat (10) step();
    chk("t4_idle", lick_out, 1'b0);
    lick_raw = 1'b1; repeat (7) step();
    sync = 1'b1; step(); step();
    lick_raw = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      step();
      chk("t4_frozen", lick_out, 1'b0);
      if (k == 1) chk("t4_clean_in_hold", lick_clean, 1'b1);
    end
    step();
    chk("t4_next", lick_out, 1'b1);
    sync = 1'b0;
    repeat (30) step();
    chk("t4_clean_gone", lick_clean, 1'b0);
    chk("t4_sticky", lick_out, 1'b1);

    // 5: saturation (narrow instance), clear on trig rise, onset coincident with trig rise
    trig = 1'b0; repeat (3) step();
    trig = 1'b1; step();
    chk("t5_cleared", lick_count, 64'd0);
    chk("t5_cleared_small", s_count, 64'd0);
    for (int n = 0; n < 10; n++) begin
      lick_raw = 1'b1; repeat (12) step();
      lick_raw = 1'b0; repeat (14) step();
    end
    chk("t5_count", lick_count, exp_count(10));
    chk("t5_sat_small", s_count, exp_count(7));
    repeat (5) step();
    chk("t5_sat_hold_small", s_count, exp_count(7));
    trig = 1'b0; repeat (2) step();
    trig = 1'b1; step();
    chk("t5_rise_clear", lick_count, 64'd0);
    chk("t5_rise_clear_small", s_count, 64'd0);
    trig = 1'b0; repeat (3) step();
    lick_raw = 1'b1; repeat (11) step();
    chk("t5_onset_now", lick_onset, 1'b1);
    trig = 1'b1; step();
    chk("t5_onset_at_rise", lick_count, exp_count(1));
    lick_raw = 1'b0; repeat (14) step();

    // 6: reset while debouncing a rise with the window flag set
    lick_raw = 1'b1; repeat (12) step();
    lick_raw = 1'b0; repeat (14) step();
    chk("t6_pre_win", lick_out, 1'b1);
    lick_raw = 1'b1; repeat (3) step();
    reset = 1'b1; step();
    chk("t6_out", lick_out, 1'b0);
    chk("t6_clean", lick_clean, 1'b0);
    chk("t6_onset", lick_onset, 1'b0);
    chk("t6_count", lick_count, 64'd0);
    reset = 1'b0; lat = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (lick_clean === 1'b1 && lat < 0) lat = i;
    end
    chk("t6_relatency", lat - 1, DB + 2);

    // Randomized run against the model
    raw_left = 1; sync_left = 1;
    for (int c = 0; c < 6000; c++) begin
      raw_left--;
      if (raw_left <= 0) begin
        lick_raw = ~lick_raw;
        raw_left = int'($urandom_range(1, 25));
      end
      sync_left--;
      if (sync_left <= 0) begin
        sync = ~sync;
        sync_left = (sync == 1'b1) ? int'($urandom_range(1, 6)) : int'($urandom_range(3, 60));
      end
      if ($urandom_range(0, 299) == 0) trig = ~trig;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
